// File: rtl/lsu_wb.sv
// Load/store and writeback stage: one operation at a time, at most one data-memory
// access, drives the register heap write port. All outputs are registered.
module lsu_wb (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is_load,
    input  logic        in_is_store,
    input  logic [2:0]  in_funct3,
    input  logic [63:0] in_addr,
    input  logic [63:0] in_sdata,
    input  logic [4:0]  in_rd,
    input  logic [63:0] in_result,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_req_addr,
    output logic        mem_req_wen,
    output logic [7:0]  mem_req_wmask,
    output logic [63:0] mem_req_wdata,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_rdata,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [63:0] rf_wdata,
    output logic        fault
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_t;

    state_t      r_state;
    logic [2:0]  r_funct3;
    logic [2:0]  r_off;
    logic [4:0]  r_rd;
    logic        r_is_load;
    logic        r_req_valid;
    logic [63:0] r_req_addr;
    logic        r_req_wen;
    logic [7:0]  r_req_wmask;
    logic [63:0] r_req_wdata;
    logic        r_rf_wen;
    logic [4:0]  r_rf_waddr;
    logic [63:0] r_rf_wdata;
    logic        r_fault;

    logic [2:0]  w_off;
    logic [2:0]  w_align;
    logic [7:0]  w_size_mask;
    logic [7:0]  w_wmask;
    logic [63:0] w_wdata;
    logic        w_illegal;
    logic        w_misaligned;
    logic        w_bad;
    logic [63:0] w_shifted;
    logic [63:0] w_load_data;

    assign w_off = in_addr[2:0];

    always_comb begin
        w_align     = 3'b000;
        w_size_mask = 8'h01;
        case (in_funct3[1:0])
            2'b00: begin w_align = 3'b000; w_size_mask = 8'h01; end
            2'b01: begin w_align = 3'b001; w_size_mask = 8'h03; end
            2'b10: begin w_align = 3'b011; w_size_mask = 8'h0F; end
            2'b11: begin w_align = 3'b111; w_size_mask = 8'hFF; end
            default: begin w_align = 3'b000; w_size_mask = 8'h01; end
        endcase
    end

    assign w_wmask      = w_size_mask << w_off;
    assign w_wdata      = in_sdata << {w_off, 3'b000};
    assign w_illegal    = in_is_load ? (in_funct3 == 3'b111) : in_funct3[2];
    assign w_misaligned = |(w_off & w_align);
    assign w_bad        = w_illegal | w_misaligned;

    // Extraction uses the offset and funct3 latched at capture, not the live inputs.
    assign w_shifted = mem_resp_rdata >> {r_off, 3'b000};

    always_comb begin
        w_load_data = w_shifted;
        case (r_funct3)
            3'b000:  w_load_data = {{56{w_shifted[7]}},  w_shifted[7:0]};
            3'b001:  w_load_data = {{48{w_shifted[15]}}, w_shifted[15:0]};
            3'b010:  w_load_data = {{32{w_shifted[31]}}, w_shifted[31:0]};
            3'b011:  w_load_data = w_shifted;
            3'b100:  w_load_data = {56'd0, w_shifted[7:0]};
            3'b101:  w_load_data = {48'd0, w_shifted[15:0]};
            3'b110:  w_load_data = {32'd0, w_shifted[31:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_funct3    <= '0;
            r_off       <= '0;
            r_rd        <= '0;
            r_is_load   <= 1'b0;
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
            r_req_wen   <= 1'b0;
            r_req_wmask <= '0;
            r_req_wdata <= '0;
            r_rf_wen    <= 1'b0;
            r_rf_waddr  <= '0;
            r_rf_wdata  <= '0;
            r_fault     <= 1'b0;
        end else begin
            r_fault <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_funct3  <= in_funct3;
                        r_off     <= w_off;
                        r_rd      <= in_rd;
                        r_is_load <= in_is_load;
                        if (!(in_is_load || in_is_store)) begin
                            r_rf_wen   <= (in_rd != 5'd0);
                            r_rf_waddr <= in_rd;
                            r_rf_wdata <= in_result;
                            r_state    <= S_WB;
                        end else if (w_bad) begin
                            r_fault <= 1'b1;
                        end else begin
                            r_req_valid <= 1'b1;
                            r_req_addr  <= {in_addr[63:3], 3'b000};
                            r_req_wen   <= in_is_store;
                            r_req_wmask <= in_is_store ? w_wmask : 8'h00;
                            r_req_wdata <= w_wdata;
                            r_state     <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        if (r_is_load) begin
                            r_rf_wen   <= (r_rd != 5'd0);
                            r_rf_waddr <= r_rd;
                            r_rf_wdata <= w_load_data;
                            r_state    <= S_WB;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_WB: begin
                    r_rf_wen <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready      = (r_state == S_IDLE);
    assign mem_req_valid = r_req_valid;
    assign mem_req_addr  = r_req_addr;
    assign mem_req_wen   = r_req_wen;
    assign mem_req_wmask = r_req_wmask;
    assign mem_req_wdata = r_req_wdata;
    assign rf_wen        = r_rf_wen;
    assign rf_waddr      = r_rf_waddr;
    assign rf_wdata      = r_rf_wdata;
    assign fault         = r_fault;

endmodule

// File: tb/tb_lsu_wb.sv
// Scenario bench for lsu_wb: register writes are scoreboarded by a monitor,
// request shaping, faults, backpressure and reset are checked inline per task.
module tb_lsu_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_is_load;
    logic        in_is_store;
    logic [2:0]  in_funct3;
    logic [63:0] in_addr;
    logic [63:0] in_sdata;
    logic [4:0]  in_rd;
    logic [63:0] in_result;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_req_wen;
    logic [7:0]  mem_req_wmask;
    logic [63:0] mem_req_wdata;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        fault;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
    } wb_t;

    wb_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    always #5 clk = ~clk;

    lsu_wb dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_sdata(in_sdata),
        .in_rd(in_rd), .in_result(in_result),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wmask(mem_req_wmask), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fault(fault)
    );

    // Every register write must match the oldest outstanding expectation.
    always @(negedge clk) begin : wb_monitor
        wb_t e;
        if (!rst && rf_wen === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL wb_unexpected: got waddr=%0d wdata=%h, required no write", rf_waddr, rf_wdata);
            end else begin
                e = exp_q.pop_front();
                if (rf_waddr !== e.rd || rf_wdata !== e.data) begin
                    n_bad++;
                    $display("FAIL wb_data: got waddr=%0d wdata=%h, required waddr=%0d wdata=%h",
                             rf_waddr, rf_wdata, e.rd, e.data);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic offer(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] sdata,
                         input logic [4:0] rd, input logic [63:0] res);
        @(negedge clk);
        in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_funct3 = f3;
        in_addr = addr; in_sdata = sdata; in_rd = rd; in_result = res;
        @(negedge clk);
        in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
        in_addr = 64'hFFFF_FFFF_FFFF_FFFF; in_sdata = 64'h5A5A_5A5A_5A5A_5A5A;
        in_rd = 5'd31; in_result = 64'hBAD0_BAD0_BAD0_BAD0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || mem_req_valid !== 1'b0 || rf_wen !== 1'b0 || fault !== 1'b0 ||
            mem_req_wen !== 1'b0 || mem_req_wmask !== 8'h00 || mem_req_addr !== 64'd0 ||
            mem_req_wdata !== 64'd0 || rf_waddr !== 5'd0 || rf_wdata !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_values: got rdy=%b rv=%b wen=%b flt=%b mwen=%b mask=%h addr=%h wd=%h wa=%0d rd=%h, required rdy=1 others 0",
                     in_ready, mem_req_valid, rf_wen, fault, mem_req_wen, mem_req_wmask,
                     mem_req_addr, mem_req_wdata, rf_waddr, rf_wdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_nonmem(input logic [4:0] rd, input logic [63:0] res);
        if (rd != 5'd0) exp_q.push_back('{rd: rd, data: res});
        offer(1'b0, 1'b0, 3'b000, 64'h0, 64'h0, rd, res);
        n_cmp++;
        if (rf_wen !== (rd != 5'd0) || in_ready !== 1'b0 || mem_req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL nonmem_c1 rd=%0d: got rf_wen=%b in_ready=%b req=%b, required rf_wen=%b in_ready=0 req=0",
                     rd, rf_wen, in_ready, mem_req_valid, (rd != 5'd0));
        end
        if (rd != 5'd0) begin
            n_cmp++;
            if (rf_waddr !== rd || rf_wdata !== res) begin
                n_bad++;
                $display("FAIL nonmem_data: got waddr=%0d wdata=%h, required %0d %h", rf_waddr, rf_wdata, rd, res);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || rf_wen !== 1'b0) begin
            n_bad++;
            $display("FAIL nonmem_c2: got in_ready=%b rf_wen=%b, required 1 0", in_ready, rf_wen);
        end
    endtask

    task automatic test_load(input string name, input logic [2:0] f3, input logic [63:0] addr,
                             input logic [63:0] rdata, input logic [4:0] rd, input logic [63:0] expv);
        logic [63:0] exp_addr;
        exp_addr = {addr[63:3], 3'b000};
        exp_q.push_back('{rd: rd, data: expv});
        offer(1'b1, 1'b0, f3, addr, 64'h0, rd, 64'h0);
        n_cmp++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== exp_addr || mem_req_wen !== 1'b0 || mem_req_wmask !== 8'h00) begin
            n_bad++;
            $display("FAIL %s_req: got v=%b addr=%h wen=%b mask=%h, required v=1 addr=%h wen=0 mask=00",
                     name, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask, exp_addr);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        n_cmp++;
        if (mem_req_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_wait: got req=%b in_ready=%b, required 0 0", name, mem_req_valid, in_ready);
        end
        mem_resp_valid = 1'b1; mem_resp_rdata = rdata;
        @(negedge clk);
        mem_resp_valid = 1'b0; mem_resp_rdata = 64'hDEAD_BEEF_CAFE_F00D;
        n_cmp++;
        if (rf_wen !== 1'b1 || rf_wdata !== expv) begin
            n_bad++;
            $display("FAIL %s_wb: got rf_wen=%b wdata=%h, required 1 %h", name, rf_wen, rf_wdata, expv);
        end
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || rf_wen !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_done: got in_ready=%b rf_wen=%b, required 1 0", name, in_ready, rf_wen);
        end
    endtask

    task automatic test_store(input string name, input logic [2:0] f3, input logic [63:0] addr,
                              input logic [63:0] sdata, input logic [7:0] exp_mask, input logic [63:0] exp_wdata);
        offer(1'b0, 1'b1, f3, addr, sdata, 5'd7, 64'h55);
        n_cmp++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== {addr[63:3], 3'b000} || mem_req_wen !== 1'b1 ||
            mem_req_wmask !== exp_mask || mem_req_wdata !== exp_wdata) begin
            n_bad++;
            $display("FAIL %s_req: got v=%b addr=%h wen=%b mask=%h wdata=%h, required v=1 addr=%h wen=1 mask=%h wdata=%h",
                     name, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask, mem_req_wdata,
                     {addr[63:3], 3'b000}, exp_mask, exp_wdata);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || rf_wen !== 1'b0 || mem_req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_ack: got in_ready=%b rf_wen=%b req=%b, required 1 0 0", name, in_ready, rf_wen, mem_req_valid);
        end
    endtask

    task automatic test_fault(input string name, input logic ld, input logic [2:0] f3, input logic [63:0] addr);
        offer(ld, !ld, f3, addr, 64'h1, 5'd4, 64'h0);
        n_cmp++;
        if (fault !== 1'b1 || in_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_pulse: got fault=%b in_ready=%b req=%b, required 1 1 0", name, fault, in_ready, mem_req_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (fault !== 1'b0 || mem_req_valid !== 1'b0 || rf_wen !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_after: got fault=%b req=%b rf_wen=%b in_ready=%b, required 0 0 0 1",
                     name, fault, mem_req_valid, rf_wen, in_ready);
        end
    endtask

    task automatic test_backpressure();
        exp_q.push_back('{rd: 5'd9, data: 64'h0123_4567_89AB_CDEF});
        offer(1'b1, 1'b0, 3'b011, 64'h2008, 64'h0, 5'd9, 64'h0);
        for (int unsigned i = 0; i < 4; i++) begin
            mem_req_ready = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h2008 || mem_req_wen !== 1'b0 || mem_req_wmask !== 8'h00) begin
                n_bad++;
                $display("FAIL bp_hold%0d: got v=%b addr=%h wen=%b mask=%h, required 1 2008 0 00",
                         i, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask);
            end
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (rf_wen !== 1'b0 || mem_req_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_early%0d: got rf_wen=%b req=%b, required 0 0", i, rf_wen, mem_req_valid);
            end
        end
        mem_resp_valid = 1'b1; mem_resp_rdata = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        n_cmp++;
        if (rf_wen !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_wb: got rf_wen=%b, required 1", rf_wen);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        offer(1'b1, 1'b0, 3'b011, 64'h3000, 64'h0, 5'd3, 64'h0);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || mem_req_valid !== 1'b0 || rf_wen !== 1'b0 || fault !== 1'b0 ||
            mem_req_wen !== 1'b0 || mem_req_wmask !== 8'h00 || mem_req_addr !== 64'd0 ||
            mem_req_wdata !== 64'd0 || rf_waddr !== 5'd0 || rf_wdata !== 64'd0) begin
            n_bad++;
            $display("FAIL rst_async: got rdy=%b addr=%h wa=%0d rd=%h, required rdy=1 others 0",
                     in_ready, mem_req_addr, rf_waddr, rf_wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_rdata = 64'h1111_2222_3333_4444;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        for (int unsigned i = 0; i < 2; i++) begin
            n_cmp++;
            if (rf_wen !== 1'b0 || in_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL rst_late_resp%0d: got rf_wen=%b in_ready=%b req=%b, required 0 1 0",
                         i, rf_wen, in_ready, mem_req_valid);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
        in_funct3 = '0; in_addr = '0; in_sdata = '0; in_rd = '0; in_result = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        test_reset();
        test_nonmem(5'd5, 64'h1234);
        test_nonmem(5'd0, 64'h1234);
        test_load("lb",  3'b000, 64'h8000_0003, 64'h0000_0000_8000_0000, 5'd10, 64'hFFFF_FFFF_FFFF_FF80);
        test_load("lbu", 3'b100, 64'h8000_0003, 64'h0000_0000_8000_0000, 5'd11, 64'h0000_0000_0000_0080);
        test_load("lh",  3'b001, 64'h0000_0002, 64'h0000_0000_F00D_0000, 5'd12, 64'hFFFF_FFFF_FFFF_F00D);
        test_load("lhu", 3'b101, 64'h0000_0002, 64'h0000_0000_F00D_0000, 5'd13, 64'h0000_0000_0000_F00D);
        test_load("lw",  3'b010, 64'h0000_0104, 64'h8765_4321_0000_0000, 5'd14, 64'hFFFF_FFFF_8765_4321);
        test_load("lwu", 3'b110, 64'h0000_0104, 64'h8765_4321_0000_0000, 5'd15, 64'h0000_0000_8765_4321);
        test_load("ld",  3'b011, 64'h0000_0010, 64'h0123_4567_89AB_CDEF, 5'd16, 64'h0123_4567_89AB_CDEF);
        test_store("sh", 3'b001, 64'h1006, 64'hABCD, 8'hC0, 64'hABCD_0000_0000_0000);
        test_store("sb", 3'b000, 64'h1003, 64'h11,   8'h08, 64'h0000_0000_1100_0000);
        test_store("sw", 3'b010, 64'h1004, 64'hDEAD_BEEF, 8'hF0, 64'hDEAD_BEEF_0000_0000);
        test_store("sd", 3'b011, 64'h1008, 64'h0102_0304_0506_0708, 8'hFF, 64'h0102_0304_0506_0708);
        test_fault("lw_misaligned", 1'b1, 3'b010, 64'h1002);
        test_fault("ld_misaligned", 1'b1, 3'b011, 64'h1004);
        test_fault("load_f3_111",   1'b1, 3'b111, 64'h1000);
        test_fault("store_f3_100",  1'b0, 3'b100, 64'h1000);
        test_fault("sh_misaligned", 1'b0, 3'b001, 64'h1001);
        test_backpressure();
        test_reset_mid_op();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL wb_missing: got %0d writes outstanding, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu_wb.md
# lsu_wb

Load/store and writeback stage of the 64-bit NPC core. It accepts one retired execute-stage operation at a time and performs at most one data-memory access. For loads it aligns and extends the returned data. It drives the single write port of the register heap (`wen`/`waddr`/`wdata`), so it sits directly upstream of the register file.

## Interface
Parameters:
- none (datapath fixed at 64 bits, 5-bit register index)

Ports:
- `clk`  in  1  — the single clock
- `rst`  in  1  — reset; asynchronous, active-high
- `in_valid`  in  1  — execute stage offers an operation
- `in_ready`  out  1  — block can accept an operation
- `in_is_load`  in  1  — operation is a load
- `in_is_store`  in  1  — operation is a store (never both set)
- `in_funct3`  in  3  — RISC-V width/sign code
- `in_addr`  in  64  — effective address for loads and stores
- `in_sdata`  in  64  — store data, unshifted
- `in_rd`  in  5  — destination register
- `in_result`  in  64  — ALU result for non-memory operations
- `mem_req_valid`  out  1  — memory request valid
- `mem_req_ready`  in  1  — memory accepts the request
- `mem_req_addr`  out  64  — `in_addr` with bits [2:0] cleared
- `mem_req_wen`  out  1  — 1 = store, 0 = load
- `mem_req_wmask`  out  8  — byte enables for the store
- `mem_req_wdata`  out  64  — store data, shifted to byte lane
- `mem_resp_valid`  in  1  — load data valid, or store acknowledged
- `mem_resp_rdata`  in  64  — the aligned 64-bit word
- `rf_wen`  out  1  — register heap write enable
- `rf_waddr`  out  5  — register heap write address
- `rf_wdata`  out  64  — register heap write data
- `fault`  out  1  — one-cycle pulse on a misaligned address or illegal funct3

## Operation
- States: IDLE, REQ, WAIT, WB. `in_ready` = (state == IDLE).
- **Capture:** on `in_valid && in_ready`, latch all `in_*` fields. Let `off` = `in_addr[2:0]`.
- **Non-memory op:** IDLE → WB. `rf_wdata` = latched `in_result`.
- **Fault check:** loads with funct3 = 111 and stores with funct3[2] = 1 are illegal. A misaligned access is one where `off` is not a multiple of 2^funct3[1:0].
  - On either condition: stay in IDLE, pulse `fault` on the next cycle.
  - No memory request and no register write.
- **Legal load/store:** IDLE → REQ.
  - Hold `mem_req_*` stable with `mem_req_valid` = 1 until `mem_req_ready`, then go to WAIT.
- **WAIT:**
  - Load: on `mem_resp_valid`, latch the extracted data and go to WB.
  - Store: on `mem_resp_valid`, go to IDLE with no register write.
- **WB:** lasts exactly one cycle, then IDLE.
  - `rf_wen` = 1 unless the latched rd = 0.
  - `rf_waddr` = rd.
- **Load extraction:** shift `mem_resp_rdata` right by off·8, then extend per funct3:
  - 000: 8-bit sign-extend
  - 001: 16-bit sign-extend
  - 010: 32-bit sign-extend
  - 011: 64-bit, no extension
  - 100: 8-bit zero-extend
  - 101: 16-bit zero-extend
  - 110: 32-bit zero-extend
- **Store shaping:**
  - `mem_req_wmask` = (0x01, 0x03, 0x0F, 0xFF per funct3[1:0]) << off.
  - `mem_req_wdata` = `in_sdata` << off·8.
  - For loads, `mem_req_wmask` = 0.
- `mem_resp_valid` is ignored outside WAIT. `mem_req_ready` is ignored outside REQ.

## Timing
- Reset values:
  - state IDLE, so `in_ready` = 1.
  - `mem_req_valid`, `rf_wen`, `fault` = 0.
  - `mem_req_wen` = 0, `mem_req_wmask` = 0.
  - all address and data outputs = 0.
- Non-memory op: accepted at cycle 0, `rf_wen` high in cycle 1, `in_ready` high again in cycle 2.
- Load, with `mem_req_ready` = 1 immediately and the response one cycle later:
  - cycle 0: accept
  - cycle 1: request
  - cycle 2: response
  - cycle 3: `rf_wen`
- Minimum store latency: accept cycle 0, request cycle 1, acknowledge cycle 2, `in_ready` high in cycle 3.
- `mem_req_*` must not change while `mem_req_valid && !mem_req_ready`.
- Reset asserted mid-operation:
  - all outputs return to reset values asynchronously and state goes to IDLE.
  - a late `mem_resp_valid` after reset is ignored.
- Each output is registered from the state or from latched fields. No input-to-output combinational path except `in_ready`, which comes from state only.

## Test plan
- Non-memory op: rd = 5, `in_result` = 0x1234 → cycle 1 shows `rf_wen` = 1, `rf_waddr` = 5, `rf_wdata` = 0x1234. The same op with rd = 0 → `rf_wen` stays 0.
- LB at addr 0x80000003, `mem_resp_rdata` = 0x00000000_80000000:
  - `mem_req_addr` = 0x80000000
  - `rf_wdata` = 0xFFFFFFFF_FFFFFF80
  - the same access as LBU gives 0x80
- SH at addr 0x1006, `in_sdata` = 0xABCD → `mem_req_wmask` = 0xC0, `mem_req_wdata` = 0xABCD000000000000, `mem_req_wen` = 1, no `rf_wen`.
- LW at addr 0x1002 → `fault` pulses once, `mem_req_valid` never rises, `in_ready` stays 1.
- Backpressure: hold `mem_req_ready` = 0 for 4 cycles during an LD → request fields stay stable. Delay `mem_resp_valid` by 3 more cycles → `rf_wen` occurs exactly one cycle after the response.
- Assert `rst` while in WAIT, then pulse `mem_resp_valid` → no `rf_wen`, `in_ready` = 1, all outputs at reset values.
